// File: rtl/kw_pipe_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kw_pipe_flow_ctrl
// Purpose  : Credit-based valid/ready wrapper around a fixed-latency,
//            non-stallable datapath, with an output FIFO that cannot overflow.
// Revision : 1.0 - initial release
// ============================================================================
module kw_pipe_flow_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           pipe_issue,
    input  logic [DATA_WIDTH-1:0]          pipe_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0] credits
);

    localparam int c_CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int c_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [c_CNT_W-1:0]    r_credits;
    logic [c_CNT_W-1:0]    r_occ;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic                  w_cap;
    logic                  w_pop;
    int                    w_inflight;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(BUF_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Reset gating keeps the handshake quiet while the registers are being cleared.
    assign in_ready   = ~reset & (r_credits != '0);
    assign pipe_issue = in_valid & in_ready;
    assign out_valid  = ~reset & (r_occ != '0);
    assign w_pop      = out_valid & out_ready;
    assign out_data   = r_mem[r_rd_ptr];
    assign credits    = r_credits;

    generate
        if (LATENCY == 0) begin : g_lat0
            assign w_cap      = pipe_issue;
            assign w_inflight = 0;
        end else begin : g_vld
            logic [LATENCY-1:0] r_vld;
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= (r_vld << 1) | LATENCY'(pipe_issue);
                end
            end
            assign w_cap      = r_vld[LATENCY-1];
            assign w_inflight = $countones(r_vld);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_credits <= c_CNT_W'(BUF_DEPTH);
        end else if (pipe_issue && !w_pop) begin
            r_credits <= r_credits - c_CNT_W'(1);
        end else if (w_pop && !pipe_issue) begin
            r_credits <= r_credits + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_occ    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_cap && !w_pop) begin
                r_occ <= r_occ + c_CNT_W'(1);
            end else if (w_pop && !w_cap) begin
                r_occ <= r_occ - c_CNT_W'(1);
            end
            if (w_cap) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
        end
    end

    // Storage is not reset: entries are only observable behind out_valid.
    always_ff @(posedge clock) begin
        if (w_cap) begin
            r_mem[r_wr_ptr] <= pipe_data;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(w_cap && (r_occ == c_CNT_W'(BUF_DEPTH))))
                else $error("kw_pipe_flow_ctrl: capture into full buffer");
            assert (!(w_pop && (r_occ == '0)))
                else $error("kw_pipe_flow_ctrl: pop from empty buffer");
            assert ((int'(r_credits) + w_inflight + int'(r_occ)) == BUF_DEPTH)
                else $error("kw_pipe_flow_ctrl: credit accounting broken");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_kw_pipe_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_kw_pipe_flow_ctrl
// Purpose  : Two configurations (LAT2/BUF4, LAT3/BUF3) driven in lockstep and
//            compared each cycle against a timestamped beat-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kw_pipe_flow_ctrl;

    localparam int c_LATS [2] = '{2, 3};
    localparam int c_BUFS [2] = '{4, 3};

    logic       clock;
    logic       reset;
    logic       in_valid  [2];
    logic       out_ready [2];
    logic [7:0] in_data;
    logic       ir [2];
    logic       pi [2];
    logic       ov [2];
    logic [7:0] od [2];
    logic [2:0] cred_a;
    logic [1:0] cred_b;
    logic [7:0] dpa [2];
    logic [7:0] dpb [3];

    typedef struct {
        int         inst;
        logic [7:0] d;
        int         vis;
    } beat_t;

    beat_t sb [$];
    int    issued [2];
    int    popped [2];
    logic  e_iss  [2];
    logic  e_pop  [2];
    int    cyc;
    int    n_chk;
    int    n_fail;
    int    n_issue_a;

    kw_pipe_flow_ctrl #(.DATA_WIDTH(8), .LATENCY(2), .BUF_DEPTH(4)) u_dut_a (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid[0]),
        .in_ready   (ir[0]),
        .pipe_issue (pi[0]),
        .pipe_data  (dpa[1]),
        .out_valid  (ov[0]),
        .out_ready  (out_ready[0]),
        .out_data   (od[0]),
        .credits    (cred_a)
    );

    kw_pipe_flow_ctrl #(.DATA_WIDTH(8), .LATENCY(3), .BUF_DEPTH(3)) u_dut_b (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid[1]),
        .in_ready   (ir[1]),
        .pipe_issue (pi[1]),
        .pipe_data  (dpb[2]),
        .out_valid  (ov[1]),
        .out_ready  (out_ready[1]),
        .out_data   (od[1]),
        .credits    (cred_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Unreset datapaths standing in for pipe-register chains.
    always @(posedge clock) begin
        dpa[0] <= in_data;
        dpa[1] <= dpa[0];
        dpb[0] <= in_data;
        dpb[1] <= dpb[0];
        dpb[2] <= dpb[1];
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int head(input int i);
        foreach (sb[k]) if (sb[k].inst == i) return k;
        return -1;
    endfunction

    function automatic int obs_cred(input int i);
        return (i == 0) ? int'(cred_a) : int'(cred_b);
    endfunction

    task automatic step(input logic v0, input logic v1, input logic r0, input logic r1,
                        input logic [7:0] d, input logic rs);
        int  h;
        int  e_cred;
        logic e_rdy;
        logic e_ov;
        in_valid[0]  = v0;
        in_valid[1]  = v1;
        out_ready[0] = r0;
        out_ready[1] = r1;
        in_data      = d;
        reset        = rs;
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            e_cred = c_BUFS[i] - issued[i] + popped[i];
            e_rdy  = !rs && (e_cred != 0);
            h      = head(i);
            e_ov   = !rs && (h >= 0) && (sb[h].vis <= cyc);
            check_eq($sformatf("in_ready[%0d]", i), int'(ir[i]), int'(e_rdy));
            check_eq($sformatf("pipe_issue[%0d]", i), int'(pi[i]), int'(in_valid[i] & e_rdy));
            check_eq($sformatf("out_valid[%0d]", i), int'(ov[i]), int'(e_ov));
            check_eq($sformatf("credits[%0d]", i), obs_cred(i), e_cred);
            if (e_ov)
                check_eq($sformatf("out_data[%0d]", i), int'(od[i]), int'(sb[h].d));
            e_iss[i] = in_valid[i] & e_rdy;
            e_pop[i] = e_ov & out_ready[i];
        end
        if (pi[0] === 1'b1) n_issue_a++;
        @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            if (rs) begin
                for (int k = sb.size() - 1; k >= 0; k--)
                    if (sb[k].inst == i) sb.delete(k);
                issued[i] = 0;
                popped[i] = 0;
            end else begin
                if (e_pop[i]) begin
                    sb.delete(head(i));
                    popped[i]++;
                end
                if (e_iss[i]) begin
                    sb.push_back('{inst: i, d: in_data, vis: cyc + c_LATS[i] + 1});
                    issued[i]++;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic rand_steps(input int n, input int pv, input int pr);
        for (int k = 0; k < n; k++)
            step($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pv,
                 $urandom_range(0, 99) < pr, $urandom_range(0, 99) < pr,
                 8'($urandom), 1'b0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        n_issue_a = 0;
        issued = '{0, 0};
        popped = '{0, 0};
        in_valid = '{1'b0, 1'b0};
        out_ready = '{1'b0, 1'b0};
        in_data = 8'h00;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        step(0, 0, 0, 0, 8'h00, 1'b1);

        // Single beat through an idle pipe.
        step(1, 1, 1, 1, 8'hA5, 1'b0);
        repeat (8) step(0, 0, 1, 1, 8'($urandom), 1'b0);

        // Full-rate streaming of 0..99.
        n_issue_a = 0;
        for (int k = 0; k < 100; k++) step(1, 1, 1, 1, 8'(k), 1'b0);
        check_eq("stream_issues_a", n_issue_a, 100);
        repeat (10) step(0, 0, 1, 1, 8'($urandom), 1'b0);

        // Backpressure: six offers into a stalled sink.
        n_issue_a = 0;
        for (int k = 0; k < 6; k++) step(1, 1, 0, 0, 8'(k), 1'b0);
        repeat (3) step(0, 0, 0, 0, 8'hEE, 1'b0);
        check_eq("bp_issues_a", n_issue_a, 4);
        check_eq("bp_credits_a", int'(cred_a), 0);
        repeat (12) step(0, 0, 1, 1, 8'($urandom), 1'b0);

        rand_steps(3000, 60, 60);
        repeat (12) step(0, 0, 1, 1, 8'($urandom), 1'b0);

        // Reset with beats both buffered and still in flight.
        step(1, 1, 0, 0, 8'h11, 1'b0);
        step(1, 1, 0, 0, 8'h22, 1'b0);
        repeat (3) step(0, 0, 0, 0, 8'h99, 1'b0);
        step(1, 1, 0, 0, 8'h33, 1'b0);
        step(1, 1, 0, 0, 8'h44, 1'b0);
        step(0, 0, 0, 0, 8'h55, 1'b1);
        check_eq("rst_credits_a", int'(cred_a), 4);
        check_eq("rst_credits_b", int'(cred_b), 3);
        repeat (6) step(0, 0, 1, 1, 8'($urandom), 1'b0);
        step(1, 1, 1, 1, 8'h3C, 1'b0);
        repeat (8) step(0, 0, 1, 1, 8'($urandom), 1'b0);

        rand_steps(2000, 80, 40);
        rand_steps(1000, 40, 85);
        repeat (12) step(0, 0, 1, 1, 8'($urandom), 1'b0);
        check_eq("drained_queue", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
